// File: rtl/matseq_pkg.sv
// Shared definitions for the matrix execution sequencer: op codes, FSM states,
// instruction field positions and one-hot unit select codes.
package matseq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_TRAN = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_STORE,
    S_HALTED
  } stateT;

  // Low bit of each instruction field; op is 4 bits, the operands 8 bits.
  localparam int OP_LSB   = 28;
  localparam int SRCA_LSB = 16;
  localparam int SRCB_LSB = 8;
  localparam int DST_LSB  = 0;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_ADD  = 4'b0001;
  localparam logic [3:0] SEL_SUB  = 4'b0010;
  localparam logic [3:0] SEL_MUL  = 4'b0100;
  localparam logic [3:0] SEL_TRAN = 4'b1000;

endpackage

// File: rtl/matseq_decode.sv
// Combinational op decode: which unit to start, whether a second operand is
// loaded, and the NOP / HALT / illegal classifications.
module matseq_decode
  import matseq_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] unitSel,
  output logic       needsB,
  output logic       isNop,
  output logic       isHalt,
  output logic       illegal
);

  always_comb begin
    unitSel = SEL_NONE;
    needsB  = 1'b0;
    isNop   = 1'b0;
    isHalt  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP:  isNop = 1'b1;
      OP_ADD:  begin unitSel = SEL_ADD; needsB = 1'b1; end
      OP_SUB:  begin unitSel = SEL_SUB; needsB = 1'b1; end
      OP_MUL:  begin unitSel = SEL_MUL; needsB = 1'b1; end
      OP_TRAN: unitSel = SEL_TRAN;
      OP_HALT: isHalt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/matrix_exec_sequencer.sv
// Fetch / load / execute / store sequencer for matrix instructions.
// Optional wait watchdog enabled by defining MATSEQ_TIMEOUT_EN.
module matrix_exec_sequencer
  import matseq_pkg::*;
#(
  parameter int DIM     = 4,
  parameter int EW      = 16,
  parameter int MAT_W   = DIM * DIM * EW,
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  output logic [PC_W-1:0]  op_addr,
  output logic             op_en,
  input  logic [31:0]      op_data,
  input  logic             op_valid,
  output logic [7:0]       mem_addr,
  output logic             mem_en,
  output logic             mem_rw,
  output logic [MAT_W-1:0] mem_wdata,
  input  logic [MAT_W-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic [3:0]       unit_sel,
  output logic             unit_en,
  output logic [MAT_W-1:0] unit_a,
  output logic [MAT_W-1:0] unit_b,
  input  logic [MAT_W-1:0] unit_result,
  input  logic             unit_done,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [PC_W-1:0]  pc
);

  stateT            stateReg;
  logic [PC_W-1:0]  pcReg;
  logic             opEnReg, memEnReg, memRwReg, unitEnReg;
  logic [7:0]       memAddrReg;
  logic [MAT_W-1:0] memWdataReg, opAReg, opBReg;
  logic [3:0]       unitSelReg;
  logic             busyReg, haltedReg, errorReg;
  logic             entryReg;
  logic [3:0]       opCodeReg;
  logic [7:0]       srcAReg, srcBReg, dstReg;

  logic [3:0] decSel;
  logic       decNeedsB, decNop, decHalt, decIllegal;
  logic       respIn, accept;
  logic       unusedOpBits;

  assign unusedOpBits = ^op_data[27:24];

  matseq_decode uDecode (
    .op      (opCodeReg),
    .unitSel (decSel),
    .needsB  (decNeedsB),
    .isNop   (decNop),
    .isHalt  (decHalt),
    .illegal (decIllegal)
  );

  // The response matching the current wait; ignored in the request cycle itself.
  always_comb begin
    respIn = 1'b0;
    case (stateReg)
      S_FETCH:                     respIn = op_valid;
      S_LOAD_A, S_LOAD_B, S_STORE: respIn = mem_valid;
      S_EXEC:                      respIn = unit_done;
      default:                     respIn = 1'b0;
    endcase
  end
  assign accept = respIn && !entryReg;

`ifdef MATSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] waitCntReg, waitCntCur;
  logic             inWait, timedOut;

  assign inWait     = stateReg inside {S_FETCH, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE};
  assign waitCntCur = entryReg ? '0 : waitCntReg;
  assign timedOut   = inWait && !accept && (waitCntCur == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (RESET || !inWait) waitCntReg <= '0;
    else                  waitCntReg <= waitCntCur + CNT_W'(1);
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      stateReg    <= S_IDLE;
      pcReg       <= '0;
      opEnReg     <= 1'b0;
      memEnReg    <= 1'b0;
      memRwReg    <= 1'b0;
      unitEnReg   <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      opAReg      <= '0;
      opBReg      <= '0;
      unitSelReg  <= SEL_NONE;
      busyReg     <= 1'b0;
      haltedReg   <= 1'b0;
      errorReg    <= 1'b0;
      entryReg    <= 1'b0;
      opCodeReg   <= '0;
      srcAReg     <= '0;
      srcBReg     <= '0;
      dstReg      <= '0;
    end else begin
      // Request strobes are single-cycle pulses unless re-armed below.
      opEnReg  <= 1'b0;
      memEnReg <= 1'b0;
      memRwReg <= 1'b0;
      entryReg <= 1'b0;
`ifdef MATSEQ_TIMEOUT_EN
      if (timedOut) begin
        unitEnReg  <= 1'b0;
        unitSelReg <= SEL_NONE;
        errorReg   <= 1'b1;
        haltedReg  <= 1'b1;
        busyReg    <= 1'b0;
        stateReg   <= S_HALTED;
      end else
`endif
      begin
        case (stateReg)
          S_IDLE: if (start) begin
            pcReg     <= '0;
            errorReg  <= 1'b0;
            haltedReg <= 1'b0;
            busyReg   <= 1'b1;
            opEnReg   <= 1'b1;
            entryReg  <= 1'b1;
            stateReg  <= S_FETCH;
          end
          S_FETCH: if (accept) begin
            opCodeReg <= op_data[OP_LSB +: 4];
            srcAReg   <= op_data[SRCA_LSB +: 8];
            srcBReg   <= op_data[SRCB_LSB +: 8];
            dstReg    <= op_data[DST_LSB +: 8];
            stateReg  <= S_DECODE;
          end
          S_DECODE: begin
            if (decIllegal || decHalt) begin
              errorReg  <= decIllegal;
              haltedReg <= 1'b1;
              busyReg   <= 1'b0;
              stateReg  <= S_HALTED;
            end else if (decNop) begin
              pcReg    <= pcReg + PC_W'(1);
              opEnReg  <= 1'b1;
              entryReg <= 1'b1;
              stateReg <= S_FETCH;
            end else begin
              memEnReg   <= 1'b1;
              memAddrReg <= srcAReg;
              entryReg   <= 1'b1;
              stateReg   <= S_LOAD_A;
            end
          end
          S_LOAD_A: if (accept) begin
            opAReg   <= mem_rdata;
            entryReg <= 1'b1;
            if (decNeedsB) begin
              memEnReg   <= 1'b1;
              memAddrReg <= srcBReg;
              stateReg   <= S_LOAD_B;
            end else begin
              unitSelReg <= decSel;
              unitEnReg  <= 1'b1;
              stateReg   <= S_EXEC;
            end
          end
          S_LOAD_B: if (accept) begin
            opBReg     <= mem_rdata;
            unitSelReg <= decSel;
            unitEnReg  <= 1'b1;
            entryReg   <= 1'b1;
            stateReg   <= S_EXEC;
          end
          S_EXEC: if (accept) begin
            unitEnReg   <= 1'b0;
            unitSelReg  <= SEL_NONE;
            memWdataReg <= unit_result;
            memEnReg    <= 1'b1;
            memRwReg    <= 1'b1;
            memAddrReg  <= dstReg;
            entryReg    <= 1'b1;
            stateReg    <= S_STORE;
          end
          S_STORE: if (accept) begin
            pcReg    <= pcReg + PC_W'(1);
            opEnReg  <= 1'b1;
            entryReg <= 1'b1;
            stateReg <= S_FETCH;
          end
          default: stateReg <= S_HALTED;
        endcase
      end
    end
  end

  assign op_addr   = pcReg;
  assign pc        = pcReg;
  assign op_en     = opEnReg;
  assign mem_addr  = memAddrReg;
  assign mem_en    = memEnReg;
  assign mem_rw    = memRwReg;
  assign mem_wdata = memWdataReg;
  assign unit_sel  = unitSelReg;
  assign unit_en   = unitEnReg;
  assign unit_a    = opAReg;
  assign unit_b    = opBReg;
  assign busy      = busyReg;
  assign halted    = haltedReg;
  assign error     = errorReg;

endmodule
